// File: rtl/flow_key_extractor.sv
// Byte-serial Ethernet/IPv4 header parser feeding the bloom-filter lookup.
// Pulls {src_ip, dst_ip, protocol} and the L4 ports out of IPv4 TCP/UDP
// frames and hands them over on a valid/ready key interface. Everything
// else (non-IPv4, other protocols, malformed or runt frames) is drained
// and counted without producing a key.
//
// state | meaning
// ETH   | MAC header, bytes 0-13, EtherType in bytes 12-13
// IP    | IPv4 header, bytes 0..IHL*4-1 (options skipped)
// L4    | first 4 bytes of TCP/UDP header (src/dst port)
// DRAIN | discard the rest of the frame until s_last
module flow_key_extractor #(
    parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [71:0]      key_ip_pro,
    output logic [15:0]      key_src_port,
    output logic [15:0]      key_dst_port,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [CNT_W-1:0] key_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {ETH, IP, L4, DRAIN} state_t;

    state_t      state;
    state_t      nxt_state;
    logic [5:0]  byte_cnt;
    logic [5:0]  nxt_cnt;
    logic [3:0]  ihl;
    logic [7:0]  eth_hi;
    logic [7:0]  proto;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [7:0]  dst_port_hi;
    logic        drain_drop;
    logic        nxt_drain_drop;
    logic        beat;
    logic        key_load;
    logic        drop_evt;
    logic        fail;
    logic [5:0]  ip_last_idx;

    // The only stall: last port byte would overwrite a key the consumer still holds.
    always_comb begin
        s_ready = !((state == L4) && (byte_cnt == 6'd3) && key_valid && !key_ready);
    end

    assign beat        = s_valid && s_ready;
    assign ip_last_idx = {ihl, 2'b00} - 6'd1;

    // Next-state decode; a failure with s_last ends the frame at once, otherwise drains it.
    always_comb begin
        nxt_state      = state;
        nxt_cnt        = byte_cnt;
        nxt_drain_drop = drain_drop;
        key_load       = 1'b0;
        drop_evt       = 1'b0;
        fail           = 1'b0;
        if (beat) begin
            nxt_cnt = byte_cnt + 6'd1;
            case (state)
                ETH: begin
                    if (byte_cnt == 6'd13) begin
                        if (({eth_hi, s_data} == ETHERTYPE_IPV4) && !s_last) begin
                            nxt_state = IP;
                            nxt_cnt   = 6'd0;
                        end else begin
                            fail = 1'b1;
                        end
                    end else if (s_last) begin
                        fail = 1'b1;
                    end
                end
                IP: begin
                    if ((byte_cnt == 6'd0) && ((s_data[7:4] != 4'd4) || (s_data[3:0] < 4'd5))) begin
                        fail = 1'b1;
                    end else if (s_last) begin
                        fail = 1'b1;
                    end else if (byte_cnt == ip_last_idx) begin
                        if ((proto == 8'd6) || (proto == 8'd17)) begin
                            nxt_state = L4;
                            nxt_cnt   = 6'd0;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
                L4: begin
                    if (byte_cnt == 6'd3) begin
                        key_load       = 1'b1;
                        nxt_state      = s_last ? ETH : DRAIN;
                        nxt_cnt        = 6'd0;
                        nxt_drain_drop = 1'b0;
                    end else if (s_last) begin
                        fail = 1'b1;
                    end
                end
                DRAIN: begin
                    if (s_last) begin
                        drop_evt       = drain_drop;
                        nxt_state      = ETH;
                        nxt_cnt        = 6'd0;
                        nxt_drain_drop = 1'b0;
                    end
                end
                default: nxt_state = ETH;
            endcase
            if (fail) begin
                if (s_last) begin
                    drop_evt       = 1'b1;
                    nxt_state      = ETH;
                    nxt_cnt        = 6'd0;
                    nxt_drain_drop = 1'b0;
                end else begin
                    nxt_state      = DRAIN;
                    nxt_drain_drop = 1'b1;
                end
            end
        end
    end

    // Parser state, header field capture, key register and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ETH;
            byte_cnt     <= 6'd0;
            drain_drop   <= 1'b0;
            ihl          <= 4'd0;
            eth_hi       <= 8'd0;
            proto        <= 8'd0;
            src_ip       <= 32'd0;
            dst_ip       <= 32'd0;
            src_port     <= 16'd0;
            dst_port_hi  <= 8'd0;
            key_ip_pro   <= 72'd0;
            key_src_port <= 16'd0;
            key_dst_port <= 16'd0;
            key_valid    <= 1'b0;
            key_cnt      <= {CNT_W{1'b0}};
            drop_cnt     <= {CNT_W{1'b0}};
        end else begin
            state      <= nxt_state;
            byte_cnt   <= nxt_cnt;
            drain_drop <= nxt_drain_drop;

            if (beat) begin
                case (state)
                    ETH: if (byte_cnt == 6'd12) eth_hi <= s_data;
                    IP: begin
                        if (byte_cnt == 6'd0) ihl <= s_data[3:0];
                        if (byte_cnt == 6'd9) proto <= s_data;
                        if ((byte_cnt >= 6'd12) && (byte_cnt <= 6'd15)) src_ip <= {src_ip[23:0], s_data};
                        if ((byte_cnt >= 6'd16) && (byte_cnt <= 6'd19)) dst_ip <= {dst_ip[23:0], s_data};
                    end
                    L4: begin
                        if (byte_cnt == 6'd0) src_port[15:8] <= s_data;
                        if (byte_cnt == 6'd1) src_port[7:0]  <= s_data;
                        if (byte_cnt == 6'd2) dst_port_hi    <= s_data;
                    end
                    default: ;
                endcase
            end

            if (key_load) begin
                key_ip_pro   <= {src_ip, dst_ip, proto};
                key_src_port <= src_port;
                key_dst_port <= {dst_port_hi, s_data};
                key_valid    <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end

            if (key_load && (key_cnt != CNT_MAX)) key_cnt <= key_cnt + CNT_ONE;
            if (drop_evt && (drop_cnt != CNT_MAX)) drop_cnt <= drop_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_flow_key_extractor.sv
// Directed bench for flow_key_extractor: frames are built in a byte array
// and streamed; a negedge monitor records every accepted key.
module tb_flow_key_extractor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [71:0] key_ip_pro;
    logic [15:0] key_src_port;
    logic [15:0] key_dst_port;
    logic        key_valid;
    logic        key_ready = 1'b1;
    logic [15:0] key_cnt;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    int          acc_cnt = 0;
    logic [71:0] acc_ip = 72'd0;
    logic [15:0] acc_sp = 16'd0;
    logic [15:0] acc_dp = 16'd0;

    logic [7:0] frm [0:127];

    flow_key_extractor #(.ETHERTYPE_IPV4(16'h0800), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .key_ip_pro(key_ip_pro), .key_src_port(key_src_port), .key_dst_port(key_dst_port),
        .key_valid(key_valid), .key_ready(key_ready),
        .key_cnt(key_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Record each key handed over (valid & ready held across the next posedge).
    always @(negedge clk) begin
        if (!reset && key_valid && key_ready) begin
            acc_cnt = acc_cnt + 1;
            acc_ip  = key_ip_pro;
            acc_sp  = key_src_port;
            acc_dp  = key_dst_port;
        end
    end

    task automatic build_frame(input int base, input logic [15:0] etype, input logic [7:0] ver_ihl,
                               input logic [7:0] proto, input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] sport, input logic [15:0] dport, input int len);
        int hl;
        int l4;
        for (int i = 0; i < len; i++) frm[base+i] = 8'h00;
        for (int i = 0; i < 12; i++) frm[base+i] = 8'h10 + 8'(i);
        frm[base+12] = etype[15:8];
        frm[base+13] = etype[7:0];
        frm[base+14] = ver_ihl;
        frm[base+23] = proto;
        frm[base+26] = src[31:24]; frm[base+27] = src[23:16];
        frm[base+28] = src[15:8];  frm[base+29] = src[7:0];
        frm[base+30] = dst[31:24]; frm[base+31] = dst[23:16];
        frm[base+32] = dst[15:8];  frm[base+33] = dst[7:0];
        hl = 4 * int'(ver_ihl[3:0]);
        for (int i = 20; i < hl; i++) frm[base+14+i] = 8'hD0 + 8'(i);
        l4 = base + 14 + hl;
        frm[l4]   = sport[15:8];
        frm[l4+1] = sport[7:0];
        frm[l4+2] = dport[15:8];
        frm[l4+3] = dport[7:0];
    endtask

    // Called and returns at posedge+1; holds the byte until accepted.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int  n;
        bit  done;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_byte_timeout actual s_ready=0 for %0d cycles required acceptance", n);
                done = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input int base, input int len);
        for (int i = 0; i < len; i++) send_byte(frm[base+i], (i == len - 1));
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid actual %0b required 0", key_valid); end
        checks++; if (key_ip_pro !== 72'd0) begin errors++; $display("FAIL reset_key_ip_pro actual %h required 0", key_ip_pro); end
        checks++; if ({key_src_port, key_dst_port} !== 32'd0) begin errors++; $display("FAIL reset_ports actual %h required 0", {key_src_port, key_dst_port}); end
        checks++; if (key_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters actual %0d/%0d required 0/0", key_cnt, drop_cnt); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready actual %0b required 1", s_ready); end
    endtask

    task automatic test_tcp();
        int a0;
        apply_reset();
        key_ready = 1'b1;
        a0 = acc_cnt;
        build_frame(0, 16'h0800, 8'h45, 8'd6, 32'hC0A8010A, 32'h0A000001, 16'h1F90, 16'h0050, 60);
        send_frame(0, 60);
        idle(4);
        checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL tcp_key_pulses actual %0d required 1", acc_cnt - a0); end
        checks++; if (acc_ip !== 72'hC0A8010A_0A000001_06) begin errors++; $display("FAIL tcp_key_ip_pro actual %h required C0A8010A0A00000106", acc_ip); end
        checks++; if (acc_sp !== 16'h1F90 || acc_dp !== 16'h0050) begin errors++; $display("FAIL tcp_ports actual %h/%h required 1f90/0050", acc_sp, acc_dp); end
        checks++; if (key_cnt !== 16'd1 || drop_cnt !== 16'd0) begin errors++; $display("FAIL tcp_counters actual %0d/%0d required 1/0", key_cnt, drop_cnt); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL tcp_key_valid_clear actual %0b required 0", key_valid); end
    endtask

    task automatic test_drops();
        int a0;
        apply_reset();
        key_ready = 1'b1;
        a0 = acc_cnt;
        build_frame(0, 16'h86DD, 8'h45, 8'd6, 32'h01020304, 32'h05060708, 16'h1111, 16'h2222, 60);
        send_frame(0, 60);
        idle(3);
        checks++; if (drop_cnt !== 16'd1 || acc_cnt !== a0) begin errors++; $display("FAIL drop_ipv6 actual drop=%0d keys=%0d required 1/0", drop_cnt, acc_cnt - a0); end
        build_frame(0, 16'h0800, 8'h45, 8'd1, 32'h01020304, 32'h05060708, 16'h1111, 16'h2222, 60);
        send_frame(0, 60);
        idle(3);
        checks++; if (drop_cnt !== 16'd2 || acc_cnt !== a0) begin errors++; $display("FAIL drop_icmp actual drop=%0d keys=%0d required 2/0", drop_cnt, acc_cnt - a0); end
        build_frame(0, 16'h0800, 8'h45, 8'd17, 32'h0A010203, 32'hAC100009, 16'h1234, 16'h0035, 60);
        send_frame(0, 60);
        idle(3);
        checks++; if (key_cnt !== 16'd1 || acc_cnt - a0 !== 1) begin errors++; $display("FAIL udp_key_cnt actual %0d required 1", key_cnt); end
        checks++; if (acc_ip !== 72'h0A010203_AC100009_11) begin errors++; $display("FAIL udp_key_ip_pro actual %h required 0A010203AC10000911", acc_ip); end
        checks++; if (acc_sp !== 16'h1234 || acc_dp !== 16'h0035) begin errors++; $display("FAIL udp_ports actual %h/%h required 1234/0035", acc_sp, acc_dp); end
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL udp_drop_cnt actual %0d required 2", drop_cnt); end
    endtask

    task automatic test_options();
        apply_reset();
        key_ready = 1'b1;
        build_frame(0, 16'h0800, 8'h46, 8'd6, 32'hC0A80001, 32'hC0A80002, 16'hABCD, 16'h01BB, 64);
        send_frame(0, 64);
        idle(3);
        checks++; if (acc_sp !== 16'hABCD || acc_dp !== 16'h01BB) begin errors++; $display("FAIL options_ports actual %h/%h required abcd/01bb", acc_sp, acc_dp); end
        checks++; if (acc_ip !== 72'hC0A80001_C0A80002_06) begin errors++; $display("FAIL options_key_ip_pro actual %h required C0A80001C0A8000206", acc_ip); end
        checks++; if (key_cnt !== 16'd1 || drop_cnt !== 16'd0) begin errors++; $display("FAIL options_counters actual %0d/%0d required 1/0", key_cnt, drop_cnt); end
    endtask

    task automatic test_back_to_back();
        int a0;
        bit stable;
        bit stall;
        bit seen;
        apply_reset();
        key_ready = 1'b0;
        a0 = acc_cnt;
        build_frame(0,  16'h0800, 8'h45, 8'd6,  32'h01010101, 32'h02020202, 16'h0001, 16'h0002, 38);
        build_frame(38, 16'h0800, 8'h45, 8'd17, 32'h03030303, 32'h04040404, 16'h0003, 16'h0004, 38);
        stable = 1'b1;
        stall  = 1'b0;
        seen   = 1'b0;
        fork
            begin
                send_frame(0, 38);
                send_frame(38, 38);
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            begin
                for (int n = 0; n < 200 && !seen; n++) begin
                    @(negedge clk);
                    seen = key_valid;
                end
                checks++; if (!seen) begin errors++; $display("FAIL b2b_first_key actual key_valid=0 required 1"); end
                repeat (50) begin
                    @(negedge clk);
                    if (key_ip_pro !== 72'h01010101_02020202_06 || key_src_port !== 16'h0001 || key_dst_port !== 16'h0002)
                        stable = 1'b0;
                    if (!s_ready) stall = 1'b1;
                end
                @(posedge clk);
                #1;
                key_ready = 1'b1;
            end
        join
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL b2b_key_stable actual changed required held"); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall actual s_ready never 0 required stall"); end
        checks++; if (acc_cnt - a0 !== 1 || acc_ip !== 72'h01010101_02020202_06) begin errors++; $display("FAIL b2b_first_accept actual n=%0d ip=%h required 1/010101010202020206", acc_cnt - a0, acc_ip); end
        checks++; if (key_valid !== 1'b1 || key_ip_pro !== 72'h03030303_04040404_11) begin errors++; $display("FAIL b2b_replace actual v=%0b ip=%h required 1/030303030404040411", key_valid, key_ip_pro); end
        idle(3);
        checks++; if (acc_cnt - a0 !== 2 || acc_sp !== 16'h0003 || acc_dp !== 16'h0004) begin errors++; $display("FAIL b2b_second_accept actual n=%0d ports=%h/%h required 2/0003/0004", acc_cnt - a0, acc_sp, acc_dp); end
        checks++; if (key_cnt !== 16'd2) begin errors++; $display("FAIL b2b_key_cnt actual %0d required 2", key_cnt); end
    endtask

    task automatic test_runt_reset();
        int a0;
        apply_reset();
        key_ready = 1'b1;
        a0 = acc_cnt;
        build_frame(0, 16'h0800, 8'h45, 8'd6, 32'hC0A8010A, 32'h0A000001, 16'h1F90, 16'h0050, 60);
        send_frame(0, 25);
        idle(3);
        checks++; if (drop_cnt !== 16'd1 || acc_cnt !== a0) begin errors++; $display("FAIL runt_drop actual drop=%0d keys=%0d required 1/0", drop_cnt, acc_cnt - a0); end
        send_frame(0, 60);
        idle(3);
        checks++; if (key_cnt !== 16'd1 || acc_ip !== 72'hC0A8010A_0A000001_06) begin errors++; $display("FAIL runt_next_good actual cnt=%0d ip=%h required 1/C0A8010A0A00000106", key_cnt, acc_ip); end
        a0 = acc_cnt;
        for (int i = 0; i < 36; i++) send_byte(frm[i], 1'b0);
        s_data  = frm[36];
        s_valid = 1'b1;
        s_last  = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        s_valid = 1'b0;
        checks++; if (key_valid !== 1'b0 || key_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL midreset_state actual v=%0b keys=%0d drops=%0d required 0/0/0", key_valid, key_cnt, drop_cnt); end
        send_frame(37, 23);
        idle(3);
        checks++; if (acc_cnt !== a0 || key_cnt !== 16'd0) begin errors++; $display("FAIL midreset_no_key actual keys=%0d required 0", acc_cnt - a0); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL midreset_tail_drop actual %0d required 1", drop_cnt); end
    endtask

    initial begin
        test_reset();
        test_tcp();
        test_drops();
        test_options();
        test_back_to_back();
        test_runt_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
